pc_fetch_sequencer: RTL
=======================

// Module: pc_fetch_sequencer
// PURPOSE
//  Owns the architectural PC register and sequences instruction fetch for the 16-bit core.
//  Issues fetch requests to the multi-cycle instruction memory and fills the IF/ID register.
//  Applies decode-stage stalls and taken-branch redirects, where the redirect target comes from the branch/PC-select logic.
//  Detects HLT at fetch and parks the front end until a redirect or reset.
// PARAMETERS
//  RESET_PC     16'h0000  PC value loaded on reset
//  HALT_OPCODE  4'hF      instr[15:12] value that halts fetch
// PORTS
//  clk             in   1   core clock; all state on rising edge
//  rst             in   1   asynchronous, active-high reset
//  stall_in        in   1   decode hazard: hold PC and IF/ID, drop request
//  redirect_valid  in   1   taken branch resolved in ID this cycle
//  redirect_pc     in   16  branch target (PC+2+2*imm or register target)
//  imem_req        out  1   fetch request; level, held until imem_ready
//  imem_addr       out  16  fetch address (= pc register)
//  imem_ready      in   1   imem_data valid for current imem_addr
//  imem_data       in   16  fetched instruction
//  if_valid        out  1   IF/ID holds a live instruction
//  if_instr        out  16  IF/ID instruction
//  if_pc_plus2     out  16  IF/ID PC+2 (branch-offset base)
//  flush           out  1   combinational: redirect_valid, squash IF/ID
//  halted          out  1   state == HALT
//  instr_count     out  16  instructions delivered to IF/ID; wraps
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, state=FETCH, if_valid=0, if_instr=16'h0,
//   if_pc_plus2=16'h0, instr_count=0, halted=0. imem_req rises first clk after rst low.
//  States: FETCH (request outstanding), STALL, HALT. 2-bit encoding.
//  imem_req = (state==FETCH) & ~stall_in & ~redirect_valid & ~rst; imem_addr = pc always.
//  Priority per cycle: redirect > stall > memory response.
//  Redirect, any state: pc<=redirect_pc; if_valid<=0; state<=FETCH.
//   A same-cycle imem_ready is discarded; instr_count does not increment.
//   Redirect out of HALT is legal, because a HLT fetched speculatively behind a branch is squashed.
//  Stall, no redirect: pc, IF/ID, and instr_count are held; state<=STALL; imem_ready is ignored.
//  STALL & ~stall_in: state<=FETCH, and the request reissues at the held pc.
//  FETCH & imem_ready & ~stall & ~redirect: IF/ID<={1,imem_data,pc+2}; pc<=pc+2; instr_count++.
//   If imem_data[15:12]==HALT_OPCODE, state<=HALT, HLT is latched in IF/ID, and pc stays at pc+2.
//  FETCH & ~imem_ready: hold pc/req. if_valid<=0 (bubble into ID).
//  HALT: imem_req=0; IF/ID is held for one cycle, then if_valid<=0. Only a redirect or rst exits.
//  Memory latency: response 1..N cycles after req with a stable addr. The addr may change only on redirect;
//   memory restarts on an addr change. There is no timeout.
//  pc+2 wraps 16'hFFFE -> 16'h0000 silently. Bit 0 of redirect_pc is forced to 0.
//  Reset mid-fetch: an outstanding response is dropped, and the request restarts at RESET_PC.
//  Zero-wait memory (ready in the req cycle) sustains 1 instr/cycle.
// STRUCTURE
//  Shared cpu_defs.vh: PC_W=16, HALT_OPCODE, state encodings FS_FETCH/FS_STALL/FS_HALT.
//  +2 increment reuses the team 16-bit adder Add_Sub_16bit (sub=0). Its ovfl output is unused.
//  There are no other sub-modules. The FSM and IF/ID registers are flat in this file.
// TESTING
//  1 Reset and zero-wait memory returning 16'h1234, 16'h5678 -> imem_addr 0,2,4; if_valid and if_pc_plus2=2,4; instr_count=2.
//  2 Memory with 3-cycle wait at pc=0x0010 -> imem_req held 3 cycles, imem_addr=0x0010, if_valid=0, then valid with pc_plus2=0x0012.
//  3 redirect_valid with redirect_pc=0x0100 and imem_ready in the same cycle -> flush=1, if_valid=0, count unchanged, next imem_addr=0x0100.
//  4 stall_in 2 cycles at pc=0x0020 -> imem_req=0 and IF/ID held; resumes at 0x0020 with no lost or duplicated instruction.
//  5 Fetch 16'hF000 at 0x0030 -> halted=1, imem_req=0 forever; then redirect to 0x0040 -> halted=0, fetch at 0x0040.
//  6 pc=0xFFFE fetch, then assert rst mid-wait at 0x0000 -> wrap to 0x0000; after rst, all outputs are at reset values and imem_addr=RESET_PC.

Source files
------------

// File: rtl/pc_fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pc_fetch_sequencer_pkg
// Purpose : Shared definitions for the fetch front end: PC width, PC step,
//           alignment mask, fetch FSM state encoding and HLT decode helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package pc_fetch_sequencer_pkg;

   localparam int              c_PC_W          = 16;
   localparam logic [15:0]     c_PC_STEP       = 16'd2;
   // Instructions are halfword aligned; bit 0 of any loaded PC is cleared.
   localparam logic [15:0]     c_PC_ALIGN_MASK = 16'hFFFE;

   typedef enum logic [1:0] {
      FS_FETCH = 2'b00,
      FS_STALL = 2'b01,
      FS_HALT  = 2'b10
   } fetch_state_t;

   function automatic logic is_halt_instr(input logic [15:0] instr,
                                          input logic [3:0]  opcode);
      return (instr[15:12] == opcode);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : pc_fetch_sequencer_if
// Purpose : Instruction-memory fetch bus between the fetch sequencer and the
//           multi-cycle instruction memory.
// Signals : imem_req   - fetch request (level, held until imem_ready)
//           imem_addr  - fetch address
//           imem_ready - imem_data valid for current imem_addr
//           imem_data  - fetched instruction
// Modports: master (fetch sequencer), slave (instruction memory)
// Revision: 1.0 - initial release
// ============================================================================
interface pc_fetch_sequencer_if;
   import pc_fetch_sequencer_pkg::*;

   logic              imem_req;
   logic [c_PC_W-1:0] imem_addr;
   logic              imem_ready;
   logic [15:0]       imem_data;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_data
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_data
   );

endinterface
`default_nettype wire

// File: rtl/pc_fetch_sequencer_add_sub.sv
`default_nettype none
// ============================================================================
// Module  : pc_fetch_sequencer_add_sub
// Purpose : 16-bit adder/subtractor (team Add_Sub_16bit datapath unit).
//           o_sum = i_a + i_b when i_sub=0, i_a - i_b when i_sub=1.
// Ports   : i_a, i_b  in  16  operands
//           i_sub     in  1   0=add, 1=subtract
//           o_sum     out 16  result (wraps modulo 2^16)
//           o_ovfl    out 1   two's-complement overflow
// Revision: 1.0 - initial release
// ============================================================================
module pc_fetch_sequencer_add_sub (
   input  wire logic [15:0] i_a,
   input  wire logic [15:0] i_b,
   input  wire logic        i_sub,
   output logic      [15:0] o_sum,
   output logic             o_ovfl
);

   logic [15:0] w_b_eff;

   // Subtraction is a + ~b + 1.
   assign w_b_eff = i_b ^ {16{i_sub}};
   assign o_sum   = i_a + w_b_eff + {15'd0, i_sub};
   assign o_ovfl  = (i_a[15] == w_b_eff[15]) && (o_sum[15] != i_a[15]);

endmodule
`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : pc_fetch_sequencer
// Purpose : Owns the architectural PC and sequences instruction fetch into
//           the IF/ID register. Handles decode stalls, taken-branch
//           redirects and HLT detection (parks the front end).
// Ports   : clk, rst          clock / async active-high reset
//           stall_in          decode hazard: hold PC and IF/ID, drop request
//           redirect_valid    taken branch resolved in ID this cycle
//           redirect_pc[15:0] branch target (bit 0 ignored)
//           imem              fetch bus (master modport)
//           if_valid          IF/ID holds a live instruction
//           if_instr[15:0]    IF/ID instruction
//           if_pc_plus2[15:0] IF/ID PC+2
//           flush             squash IF/ID (= redirect_valid)
//           halted            front end parked on HLT
//           instr_count[15:0] instructions delivered to IF/ID (wraps)
// Revision: 1.0 - initial release
// ============================================================================
module pc_fetch_sequencer
   import pc_fetch_sequencer_pkg::*;
#(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
   input  wire logic          clk,
   input  wire logic          rst,
   input  wire logic          stall_in,
   input  wire logic          redirect_valid,
   input  wire logic [15:0]   redirect_pc,
   pc_fetch_sequencer_if.master imem,
   output logic               if_valid,
   output logic [15:0]        if_instr,
   output logic [15:0]        if_pc_plus2,
   output logic               flush,
   output logic               halted,
   output logic [15:0]        instr_count
);

   fetch_state_t r_state;
   logic [15:0]  r_pc;
   logic         r_if_valid;
   logic [15:0]  r_if_instr;
   logic [15:0]  r_if_pc_plus2;
   logic [15:0]  r_instr_count;
   logic         r_halted;

   logic [15:0]  w_pc_plus2;
   logic         w_add_ovfl_unused;

   pc_fetch_sequencer_add_sub u_pc_inc (
      .i_a    (r_pc),
      .i_b    (c_PC_STEP),
      .i_sub  (1'b0),
      .o_sum  (w_pc_plus2),
      .o_ovfl (w_add_ovfl_unused)
   );

   // The request is dropped combinationally in any cycle whose outcome is
   // already decided by a higher-priority event, so memory never sees a
   // request whose response would be thrown away.
   assign imem.imem_req  = (r_state == FS_FETCH) & ~stall_in & ~redirect_valid & ~rst;
   assign imem.imem_addr = r_pc;

   assign flush       = redirect_valid;
   assign if_valid    = r_if_valid;
   assign if_instr    = r_if_instr;
   assign if_pc_plus2 = r_if_pc_plus2;
   assign instr_count = r_instr_count;
   assign halted      = r_halted;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= FS_FETCH;
         r_pc          <= RESET_PC;
         r_if_valid    <= 1'b0;
         r_if_instr    <= 16'h0000;
         r_if_pc_plus2 <= 16'h0000;
         r_instr_count <= 16'h0000;
         r_halted      <= 1'b0;
      end else if (redirect_valid) begin
         // Redirect wins over everything, including HALT: a HLT fetched
         // behind a taken branch is on the wrong path.
         r_pc       <= redirect_pc & c_PC_ALIGN_MASK;
         r_if_valid <= 1'b0;
         r_state    <= FS_FETCH;
         r_halted   <= 1'b0;
      end else if (stall_in) begin
         // Everything holds; HALT stays parked since only redirect/rst exit it.
         if (r_state != FS_HALT) begin
            r_state <= FS_STALL;
         end
      end else begin
         case (r_state)
            FS_FETCH: begin
               if (imem.imem_ready) begin
                  r_if_valid    <= 1'b1;
                  r_if_instr    <= imem.imem_data;
                  r_if_pc_plus2 <= w_pc_plus2;
                  r_pc          <= w_pc_plus2;
                  r_instr_count <= r_instr_count + 16'd1;
                  if (is_halt_instr(imem.imem_data, HALT_OPCODE)) begin
                     r_state  <= FS_HALT;
                     r_halted <= 1'b1;
                  end
               end else begin
                  r_if_valid <= 1'b0;
               end
            end
            FS_STALL: begin
               // ID consumes the held instruction on this edge; nothing new
               // was fetched, so a bubble follows it.
               r_state    <= FS_FETCH;
               r_if_valid <= 1'b0;
            end
            FS_HALT: begin
               // HLT stays visible for the first HALT cycle only.
               r_if_valid <= 1'b0;
            end
            default: begin
               r_state    <= FS_FETCH;
               r_if_valid <= 1'b0;
               r_halted   <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
